// File: rtl/sram_block_reader_if.sv
// Bundle of the reader's control, stream and SRAM-requester signals.
// master = the reader itself, slave = its environment (control, consumer, controller).
interface sram_block_reader_if #(
  parameter int unsigned ADDR_WIDTH = 3,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  start;
  logic [ADDR_WIDTH-1:0] start_addr;
  logic [ADDR_WIDTH:0]   num_words;
  logic                  busy;
  logic                  done;
  logic                  rd_error;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_last;
  logic                  memctrl_enable;
  logic                  memctrl_rw;
  logic [ADDR_WIDTH-1:0] memctrl_addr;
  logic [DATA_WIDTH-1:0] memctrl_write_data;
  logic                  dat_ready;
  logic [DATA_WIDTH-1:0] memctrl_out_data;

  modport master (
    input  start, start_addr, num_words, out_ready, dat_ready, memctrl_out_data,
    output busy, done, rd_error, out_valid, out_data, out_last,
           memctrl_enable, memctrl_rw, memctrl_addr, memctrl_write_data
  );

  modport slave (
    output start, start_addr, num_words, out_ready, dat_ready, memctrl_out_data,
    input  busy, done, rd_error, out_valid, out_data, out_last,
           memctrl_enable, memctrl_rw, memctrl_addr, memctrl_write_data
  );
endinterface

// File: rtl/sram_block_reader.sv
// Issues single-word SRAM reads at consecutive addresses and streams each word out.
// Optional read timeout enabled by defining SRAM_RD_TIMEOUT_EN.
module sram_block_reader #(
  parameter int unsigned ADDR_WIDTH = 3,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT    = 8
) (
  input logic                clock,
  input logic                reset,
  sram_block_reader_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_HOLD,
    S_DONE
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH:0]   r_cnt;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_last;
  logic                  w_timeout;

`ifdef SRAM_RD_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] r_wait_cnt;
  logic          r_err;

  // dat_ready takes priority over the final timeout cycle
  assign w_timeout = (r_state == S_WAIT) && !bus.dat_ready &&
                     (r_wait_cnt == CW'(TIMEOUT - 1));
`else
  assign w_timeout = 1'b0;
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.start) w_next = (bus.num_words == '0) ? S_DONE : S_ISSUE;
      S_ISSUE: w_next = S_WAIT;
      S_WAIT: begin
        if (bus.dat_ready)  w_next = S_HOLD;
        else if (w_timeout) w_next = S_DONE;
      end
      S_HOLD:  if (bus.out_ready) w_next = r_last ? S_DONE : S_ISSUE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_cnt   <= '0;
      r_data  <= '0;
      r_last  <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: if (bus.start) begin
          r_addr <= bus.start_addr;
          r_cnt  <= bus.num_words;
        end
        S_WAIT: if (bus.dat_ready) begin
          r_data <= bus.memctrl_out_data;
          r_last <= (r_cnt == (ADDR_WIDTH + 1)'(1));
        end
        S_HOLD: if (bus.out_ready) begin
          r_cnt  <= r_cnt - (ADDR_WIDTH + 1)'(1);
          r_addr <= r_addr + ADDR_WIDTH'(1);
        end
        default: ;
      endcase
    end
  end

`ifdef SRAM_RD_TIMEOUT_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      r_wait_cnt <= '0;
      r_err      <= 1'b0;
    end else begin
      if (r_state == S_ISSUE)     r_wait_cnt <= '0;
      else if (r_state == S_WAIT) r_wait_cnt <= r_wait_cnt + CW'(1);
      if (r_state == S_IDLE && bus.start) r_err <= 1'b0;
      else if (w_timeout)                 r_err <= 1'b1;
    end
  end
  assign bus.rd_error = r_err;
`else
  assign bus.rd_error = 1'b0;
`endif

  assign bus.busy               = (r_state != S_IDLE);
  assign bus.done               = (r_state == S_DONE);
  assign bus.out_valid          = (r_state == S_HOLD);
  assign bus.out_data           = r_data;
  assign bus.out_last           = r_last;
  assign bus.memctrl_enable     = (r_state == S_ISSUE);
  assign bus.memctrl_rw         = 1'b0;
  assign bus.memctrl_addr       = r_addr;
  assign bus.memctrl_write_data = '0;

endmodule

// File: tb/tb_sram_block_reader.sv
// Self-checking bench for sram_block_reader with a 2-cycle-latency SRAM controller model
// preloaded with word[i] = 0xA5A50000 + i; timeout scenario built when SRAM_RD_TIMEOUT_EN is defined.
module tb_sram_block_reader;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  sram_block_reader_if #(.ADDR_WIDTH(3), .DATA_WIDTH(32)) bus ();

  sram_block_reader #(.ADDR_WIDTH(3), .DATA_WIDTH(32), .TIMEOUT(8)) u_dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_err    = 0;

  // Controller model: request registered, data returned two cycles after the enable cycle.
  // It ignores reset so that an in-flight response can arrive after the reader is reset.
  logic       suppress = 1'b0;
  logic       p1 = 1'b0, p2 = 1'b0;
  logic [2:0] a1 = '0, a2 = '0;
  always @(posedge clock) begin
    p1 <= bus.memctrl_enable;
    a1 <= bus.memctrl_addr;
    p2 <= p1 & ~suppress;
    a2 <= a1;
  end
  assign bus.dat_ready        = p2;
  assign bus.memctrl_out_data = p2 ? (32'hA5A5_0000 + {29'd0, a2}) : 32'hDEAD_BEEF;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // One run starting in the current (IDLE) cycle, which is cycle 0.
  // mode: 0 = no backpressure, 1 = 5 stall cycles on word 2, 2 = random stalls per word.
  task automatic run(input int sa, input int nw, input int mode, input bit poke, input bit hold_start);
    int stall[$];
    int exp_done = 1;
    int k = 0, stalled = 0, enables = 0, dones = 0, done_c = -1, first_v = -1;
    bit fin = 0;
    logic [31:0] ew;
    for (int i = 0; i < nw; i++) begin
      int s;
      s = (mode == 2) ? int'($urandom_range(0, 3)) : ((mode == 1 && i == 2) ? 5 : 0);
      stall.push_back(s);
      exp_done += 4 + s;
    end
    bus.start      = 1'b1;
    bus.start_addr = 3'(sa);
    bus.num_words  = 4'(nw);
    for (int c = 1; c <= 400 && !fin; c++) begin
      step();
      if (c == 1 && !hold_start) bus.start = 1'b0;
      if (c == 2) begin
        bus.start      = poke;
        bus.start_addr = 3'(sa + 3);
        bus.num_words  = 4'd0;
      end
      if (c == 3) bus.start = 1'b0;
      if (bus.memctrl_enable) begin
        chk("issue_addr", bus.memctrl_addr, (sa + enables) % 8);
        chk("rw_wdata", {bus.memctrl_rw, bus.memctrl_write_data}, 0);
        enables++;
      end
      if (bus.out_valid) begin
        if (first_v < 0) first_v = c;
        if (k < nw) begin
          ew = 32'hA5A5_0000 + 32'((sa + k) % 8);
          chk("out_data", bus.out_data, ew);
          chk("out_last", bus.out_last, (k == nw - 1));
          if (stalled < stall[k]) begin
            bus.out_ready = 1'b0;
            stalled++;
          end else begin
            bus.out_ready = 1'b1;
            k++;
            stalled = 0;
          end
        end else begin
          bus.out_ready = 1'b1;
          k++;
        end
      end else begin
        bus.out_ready = 1'($urandom);
      end
      if (bus.done) begin
        dones++;
        if (done_c < 0) begin
          done_c = c;
          chk("busy_at_done", bus.busy, 1);
          chk("rd_error_clear", bus.rd_error, 0);
        end
      end
      if (done_c >= 0 && c == done_c + 1) begin
        chk("busy_after_done", bus.busy, 0);
        chk("done_one_cycle", bus.done, 0);
        fin = 1;
      end
    end
    bus.out_ready = 1'b1;
    chk("word_count", k, nw);
    chk("enable_count", enables, nw);
    chk("done_cycle", done_c, exp_done);
    chk("done_count", dones, 1);
    chk("first_valid_cycle", first_v, (nw == 0) ? -1 : 4);
  endtask

  initial begin
    int sa;
    int enables;
    bus.start      = 1'b0;
    bus.start_addr = '0;
    bus.num_words  = '0;
    bus.out_ready  = 1'b0;
    reset = 1'b1;
    repeat (3) step();
    chk("reset_ctrl", {bus.busy, bus.done, bus.rd_error, bus.out_valid, bus.out_last,
                       bus.memctrl_enable, bus.memctrl_rw, bus.memctrl_addr}, 0);
    chk("reset_data", {bus.out_data, bus.memctrl_write_data}, 0);
    reset = 1'b0;
    step();

    run(0, 8, 0, 0, 0);   // full sweep, done in cycle 33
    run(6, 4, 0, 0, 0);   // address wrap 6,7,0,1
    run(0, 8, 1, 0, 0);   // 5-cycle stall on word 2
    run(3, 0, 0, 0, 1);   // zero-length run, start held into DONE
    run(5, 10, 0, 1, 0);  // more words than addresses, start poked while busy
    for (int i = 0; i < 4; i++)
      run(int'($urandom_range(0, 7)), int'($urandom_range(1, 12)), 2, 1'($urandom), 0);

    // Reset in WAIT of word 3; the response still in flight must be ignored.
    sa = int'($urandom_range(0, 7));
    enables = 0;
    bus.out_ready  = 1'b1;
    bus.start      = 1'b1;
    bus.start_addr = 3'(sa);
    bus.num_words  = 4'd5;
    for (int c = 1; c <= 14; c++) begin
      step();
      if (c == 1) bus.start = 1'b0;
      if (bus.memctrl_enable) enables++;
    end
    chk("enables_before_reset", enables, 4);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("midrun_reset_ctrl", {bus.busy, bus.done, bus.rd_error, bus.out_valid, bus.out_last,
                              bus.memctrl_enable, bus.memctrl_rw, bus.memctrl_addr}, 0);
    chk("midrun_reset_data", {bus.out_data, bus.memctrl_write_data}, 0);
    step();
    chk("stale_resp_ignored", {bus.busy, bus.out_valid}, 0);
    step();
    chk("still_idle", {bus.busy, bus.out_valid}, 0);
    run(int'($urandom_range(0, 7)), 2, 0, 0, 0);

`ifdef SRAM_RD_TIMEOUT_EN
    begin
      int done_c = -1, valids = 0, ens = 0;
      suppress = 1'b1;
      bus.start      = 1'b1;
      bus.start_addr = 3'd2;
      bus.num_words  = 4'd3;
      for (int c = 1; c <= 30 && done_c < 0; c++) begin
        step();
        if (c == 1) bus.start = 1'b0;
        if (bus.memctrl_enable) ens++;
        if (bus.out_valid) valids++;
        if (bus.done) begin
          done_c = c;
          chk("timeout_rd_error", bus.rd_error, 1);
        end
      end
      chk("timeout_done_cycle", done_c, 10);
      chk("timeout_no_valid", valids, 0);
      chk("timeout_enables", ens, 1);
      step();
      chk("rd_error_sticky", {bus.busy, bus.rd_error}, 2'b01);
      suppress = 1'b0;
      run(1, 3, 0, 0, 0);
    end
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
